rover_quad_decoder: RTL and testbench

Avalon-MM slave that decodes the two rover wheel quadrature encoders (A/B pairs) into signed position counters, with glitch filtering, illegal-transition detection and maskable interrupts. It sits on the NIOS system bus beside the encoder edge-capture PIO and offloads per-edge counting from software: the CPU reads positions instead of servicing every encoder edge.

---
 rtl/rover_quad_pkg.sv | 45 ++++
 rtl/rover_quad_channel.sv | 91 +++++++++
 rtl/rover_quad_decoder.sv | 96 +++++++++
 tb/tb_rover_quad_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rover_quad_pkg.sv
// Shared definitions for the rover wheel quadrature decoder: register map,
// event bit positions and the x4 quadrature step decode.
package rover_quad_pkg;

    localparam logic [1:0] ADDR_COUNT0   = 2'd0;
    localparam logic [1:0] ADDR_COUNT1   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EVENT    = 2'd3;

    localparam int EV_STEP0 = 0;
    localparam int EV_STEP1 = 1;
    localparam int EV_ERR0  = 2;
    localparam int EV_ERR1  = 3;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC,
        STEP_ILLEGAL
    } step_t;

    // Position of an {A,B} level along the forward Gray sequence 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b01:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] next_pos;
        next_pos = gray_pos(prev) + 2'd1;
        if (prev == cur)
            decode_step = STEP_NONE;
        else if ((prev ^ cur) == 2'b11)
            decode_step = STEP_ILLEGAL;
        else if (gray_pos(cur) == next_pos)
            decode_step = STEP_INC;
        else
            decode_step = STEP_DEC;
    endfunction

endpackage

// File: rtl/rover_quad_channel.sv
// One encoder channel: synchronizer, per-bit glitch filter, priming,
// x4 decode and the wrapping signed position counter.
module rover_quad_channel
    import rover_quad_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              enc_ab,
    input  logic                    load,
    input  logic signed [CNT_W-1:0] load_value,
    output logic signed [CNT_W-1:0] count,
    output logic                    step,
    output logic                    err
);

    // Long enough for a level held through reset to reach the filter output.
    localparam int PRIME_CYC = FILT_LEN + 4;
    localparam int PW        = $clog2(PRIME_CYC);
    localparam logic signed [CNT_W-1:0] ONE = 1;

    logic [1:0]    sync_p0, sync_p1;
    logic [1:0]    filt_p2;
    logic [3:0]    run_cnt [2];
    logic [1:0]    prev_p3;
    logic          primed;
    logic [PW-1:0] prime_cnt;
    step_t         dec;

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= enc_ab;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: a bit flips only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_p2    <= '0;
            run_cnt[0] <= '0;
            run_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt_p2[i]) begin
                    run_cnt[i] <= '0;
                end else if (run_cnt[i] == 4'(FILT_LEN)) begin
                    filt_p2[i] <= sync_p1[i];
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign dec  = decode_step(prev_p3, filt_p2);
    assign step = primed && !load && ((dec == STEP_INC) || (dec == STEP_DEC));
    assign err  = primed && (dec == STEP_ILLEGAL);

    // Stage p3: decode against the previous filtered level, then count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_p3   <= '0;
            primed    <= 1'b0;
            prime_cnt <= '0;
            count     <= '0;
        end else begin
            prev_p3 <= filt_p2;
            if (!primed) begin
                if (prime_cnt == PW'(PRIME_CYC - 1))
                    primed <= 1'b1;
                else
                    prime_cnt <= prime_cnt + 1'b1;
            end
            if (load)
                count <= load_value;
            else if (primed && (dec == STEP_INC))
                count <= count + ONE;
            else if (primed && (dec == STEP_DEC))
                count <= count - ONE;
        end
    end

endmodule

// File: rtl/rover_quad_decoder.sv
// Avalon-MM slave exposing two quadrature position counters, a sticky
// event register with write-1-to-clear, and a maskable level interrupt.
module rover_quad_decoder
    import rover_quad_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  in_port,
    output logic        irq
);

    logic                    write_en;
    logic                    load0, load1;
    logic signed [CNT_W-1:0] load_value;
    logic signed [CNT_W-1:0] count0, count1;
    logic                    step0, step1, err0, err1;
    logic [3:0]              new_ev;
    logic [3:0]              ev_q;
    logic [3:0]              irq_mask_q;
    logic                    unused_wdata;

    assign write_en     = chipselect && !write_n;
    assign load0        = write_en && (address == ADDR_COUNT0);
    assign load1        = write_en && (address == ADDR_COUNT1);
    assign load_value   = writedata[CNT_W-1:0];
    assign unused_wdata = ^writedata;

    rover_quad_channel #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_ch0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enc_ab     ({in_port[0], in_port[1]}),
        .load       (load0),
        .load_value (load_value),
        .count      (count0),
        .step       (step0),
        .err        (err0)
    );

    rover_quad_channel #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_ch1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enc_ab     ({in_port[2], in_port[3]}),
        .load       (load1),
        .load_value (load_value),
        .count      (count1),
        .step       (step1),
        .err        (err1)
    );

    always_comb begin
        new_ev           = '0;
        new_ev[EV_STEP0] = step0;
        new_ev[EV_STEP1] = step1;
        new_ev[EV_ERR0]  = err0;
        new_ev[EV_ERR1]  = err1;
    end

    // A new event in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_q       <= '0;
            irq_mask_q <= '0;
        end else begin
            if (write_en && (address == ADDR_EVENT))
                ev_q <= (ev_q & ~writedata[3:0]) | new_ev;
            else
                ev_q <= ev_q | new_ev;
            if (write_en && (address == ADDR_IRQ_MASK))
                irq_mask_q <= writedata[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_COUNT0:   readdata <= 32'(count0);
                ADDR_COUNT1:   readdata <= 32'(count1);
                ADDR_IRQ_MASK: readdata <= {28'd0, irq_mask_q};
                default:       readdata <= {28'd0, ev_q};
            endcase
        end
    end

    assign irq = |(ev_q & irq_mask_q);

endmodule

// File: tb/tb_rover_quad_decoder.sv
// Directed bench for rover_quad_decoder: a 32-bit-counter instance carries the
// main sequence, a 16-bit-counter instance checks sign extension on wrap.
module tb_rover_quad_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    logic [1:0]  address16;
    logic        chipselect16;
    logic        write_n16;
    logic [31:0] writedata16;
    logic [31:0] readdata16;
    logic        irq16;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rover_quad_decoder #(.CNT_W(32), .FILT_LEN(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    rover_quad_decoder #(.CNT_W(16), .FILT_LEN(4)) dut16 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address16),
        .chipselect (chipselect16),
        .write_n    (write_n16),
        .writedata  (writedata16),
        .readdata   (readdata16),
        .in_port    (in_port),
        .irq        (irq16)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick(1);
        chk(tag, readdata, exp);
    endtask

    task automatic bus_write16(input logic [1:0] a, input logic [31:0] d);
        address16    = a;
        writedata16  = d;
        chipselect16 = 1'b1;
        write_n16    = 1'b0;
        tick(1);
        chipselect16 = 1'b0;
        write_n16    = 1'b1;
    endtask

    task automatic rd16_chk(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address16 = a;
        tick(1);
        chk(tag, readdata16, exp);
    endtask

    // ab is {A,B}
    task automatic set_ch(input int ch, input logic [1:0] ab);
        if (ch == 0) begin
            in_port[0] = ab[1];
            in_port[1] = ab[0];
        end else begin
            in_port[2] = ab[1];
            in_port[3] = ab[0];
        end
    endtask

    task automatic move(input int ch, input logic [1:0] ab);
        set_ch(ch, ab);
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        in_port      = 4'b1111;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'd0;
        address16    = 2'd0;
        chipselect16 = 1'b0;
        write_n16    = 1'b1;
        writedata16  = 32'd0;

        // Reset with both encoders parked at 11
        tick(3);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        tick(20);
        rd_chk(2'd0, "prime_count0", 32'd0);
        rd_chk(2'd1, "prime_count1", 32'd0);
        rd_chk(2'd3, "prime_event", 32'd0);
        chk("prime_irq", {31'd0, irq}, 32'd0);

        // Walk ch0 from 11 to 00 legally, then clear
        move(0, 2'b10);
        move(0, 2'b00);
        bus_write(2'd0, 32'd0);
        bus_write(2'd3, 32'hF);

        // Forward sequence: four +1 steps
        move(0, 2'b01);
        move(0, 2'b11);
        move(0, 2'b10);
        move(0, 2'b00);
        rd_chk(2'd0, "fwd_count0", 32'd4);
        rd_chk(2'd3, "fwd_event", 32'h1);

        // Reverse sequence twice: eight -1 steps
        for (int r = 0; r < 2; r++) begin
            move(0, 2'b10);
            move(0, 2'b11);
            move(0, 2'b01);
            move(0, 2'b00);
        end
        rd_chk(2'd0, "rev_count0", 32'hFFFF_FFFC);

        // Interrupt latency: step lands on the 8th edge after the input change
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h1);
        rd_chk(2'd2, "mask_readback", 32'h1);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        set_ch(0, 2'b01);
        tick(7);
        chk("irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        chk("irq_on_step", {31'd0, irq}, 32'd1);
        tick(2);
        bus_write(2'd3, 32'h1);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);

        // W1C on the same edge as a new step: the set wins
        set_ch(0, 2'b11);
        tick(7);
        bus_write(2'd3, 32'h1);
        rd_chk(2'd3, "w1c_vs_set", 32'h1);
        tick(2);
        rd_chk(2'd0, "count0_after_irq", 32'hFFFF_FFFE);

        // Ch1: legal walk to 00, then an illegal 00->11 jump
        move(1, 2'b10);
        move(1, 2'b00);
        bus_write(2'd3, 32'hF);
        move(1, 2'b11);
        rd_chk(2'd3, "illegal_event", 32'h8);
        rd_chk(2'd1, "illegal_count1", 32'd2);

        // 3-cycle glitch on A1 is filtered away
        bus_write(2'd3, 32'hF);
        in_port[2] = 1'b0;
        tick(3);
        in_port[2] = 1'b1;
        tick(12);
        rd_chk(2'd3, "glitch_event", 32'h0);
        rd_chk(2'd1, "glitch_count1", 32'd2);

        // Wrap from max positive to max negative
        bus_write(2'd0, 32'h7FFF_FFFF);
        bus_write16(2'd0, 32'h0000_7FFF);
        move(0, 2'b10);
        rd_chk(2'd0, "wrap32_count0", 32'h8000_0000);
        rd16_chk(2'd0, "wrap16_count0", 32'hFFFF_8000);

        // COUNT1 write on the same edge as a ch1 step: the write wins
        set_ch(1, 2'b10);
        tick(7);
        bus_write(2'd1, 32'd100);
        tick(3);
        rd_chk(2'd1, "load_vs_step", 32'd100);

        // Reset in the middle of a ch0 transition
        set_ch(0, 2'b00);
        tick(4);
        chk("irq_pre_reset", {31'd0, irq}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_readdata", readdata, 32'd0);
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        rd_chk(2'd0, "reprime_count0", 32'd0);
        rd_chk(2'd1, "reprime_count1", 32'd0);
        rd_chk(2'd2, "reprime_mask", 32'd0);
        rd_chk(2'd3, "reprime_event", 32'd0);

        // Decoding resumes after priming from ch1 = 10
        move(1, 2'b00);
        rd_chk(2'd1, "post_reset_count1", 32'd1);
        rd_chk(2'd3, "post_reset_event", 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
